// File: rtl/vga_pkg.sv
// vga_pkg: shared colour, scancode, display-mode and prefix-state definitions
// for the VGA mode scheduler.
package vga_pkg;
  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] GREEN = 12'h080;
  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] BLUE  = 12'h00F;
  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_R     = 8'h2D;
  typedef enum logic [1:0] {MODE_BARS, MODE_SOLID, MODE_GRAD, MODE_CHECK} mode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} ps2_state_t;
  function automatic logic [11:0] color_lut(input logic [1:0] idx);
    return idx == 2'd0 ? GREEN : idx == 2'd1 ? RED : idx == 2'd2 ? BLUE : WHITE;
  endfunction
endpackage

// File: rtl/ps2_cmd_decode.sv
// ps2_cmd_decode: PS/2 set-2 prefix tracker with frame-based timeout; turns
// make codes seen in IDLE into one-cycle command strobes.
module ps2_cmd_decode
  import vga_pkg::*;
(
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic       i_key_valid,
  input  logic [7:0] i_key_code,
  input  logic       i_frame_start,
  output logic       o_set_mode,
  output mode_t      o_mode_val,
  output logic       o_tog_auto,
  output logic       o_step_color
);
  ps2_state_t r_state;
  logic       r_tmo;
  logic       w_idle_key;
  assign w_idle_key   = i_key_valid && r_state == ST_IDLE;
  assign o_set_mode   = w_idle_key && (i_key_code == SC_1 || i_key_code == SC_2 ||
                                       i_key_code == SC_3 || i_key_code == SC_4);
  assign o_mode_val   = i_key_code == SC_2 ? MODE_SOLID :
                        i_key_code == SC_3 ? MODE_GRAD  :
                        i_key_code == SC_4 ? MODE_CHECK : MODE_BARS;
  assign o_tog_auto   = w_idle_key && i_key_code == SC_A;
  assign o_step_color = w_idle_key && i_key_code == SC_R;
  // r_tmo marks one frame boundary seen since the last byte while mid-prefix
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tmo   <= 1'b0;
    end else if (i_key_valid) begin
      r_tmo   <= 1'b0;
      r_state <= r_state == ST_IDLE ? (i_key_code == SC_BREAK ? ST_BRK :
                                       i_key_code == SC_EXT   ? ST_EXT : ST_IDLE) :
                 r_state == ST_EXT  ? (i_key_code == SC_BREAK ? ST_EXT_BRK : ST_IDLE) :
                 ST_IDLE;
    end else if (i_frame_start && r_state != ST_IDLE) begin
      r_tmo <= !r_tmo;
      if (r_tmo) r_state <= ST_IDLE;
    end
  end
endmodule

// File: rtl/vga_mode_ctrl.sv
// vga_mode_ctrl: holds decoded display commands in shadow registers and
// applies them atomically at frame_start, with optional pattern auto-cycling.
module vga_mode_ctrl
  import vga_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 60,
  parameter int FCNT_W          = 12
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  input  logic        frame_start,
  output logic [1:0]  mode,
  output logic [11:0] solid_color,
  output logic        auto_en,
  output logic        cmd_pending
);
  logic              w_set_mode, w_tog_auto, w_step_color, w_cmd, w_step;
  mode_t             w_mode_val, w_auto_mode;
  mode_t             r_mode, r_sh_mode;
  logic [1:0]        r_sh_cidx;
  logic              r_sh_auto, r_auto, r_pending, r_man;
  logic [11:0]       r_color;
  logic [FCNT_W-1:0] r_fcnt;
  ps2_cmd_decode u_dec (
    .vga_clk      (vga_clk),
    .rst_n        (rst_n),
    .i_key_valid  (key_valid),
    .i_key_code   (key_code),
    .i_frame_start(frame_start),
    .o_set_mode   (w_set_mode),
    .o_mode_val   (w_mode_val),
    .o_tog_auto   (w_tog_auto),
    .o_step_color (w_step_color)
  );
  assign w_cmd       = w_set_mode | w_tog_auto | w_step_color;
  assign w_step      = r_auto && r_fcnt == FCNT_W'(FRAMES_PER_STEP - 1);
  assign w_auto_mode = mode_t'(r_mode + 2'd1);
  assign mode        = r_mode;
  assign solid_color = r_color;
  assign auto_en     = r_auto;
  assign cmd_pending = r_pending;
  // Apply uses the shadow as it stood before this cycle; same-cycle commands roll to the next frame
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= MODE_BARS;
      r_sh_mode <= MODE_BARS;
      r_sh_cidx <= 2'd0;
      r_sh_auto <= 1'b0;
      r_auto    <= 1'b0;
      r_color   <= GREEN;
      r_pending <= 1'b0;
      r_man     <= 1'b0;
      r_fcnt    <= '0;
    end else begin
      r_sh_cidx <= r_sh_cidx + 2'(w_step_color);
      r_sh_auto <= r_sh_auto ^ w_tog_auto;
      r_man     <= w_set_mode | (r_man & !frame_start);
      r_pending <= w_cmd | (r_pending & !frame_start);
      if (w_set_mode) r_sh_mode <= w_mode_val;
      else if (frame_start && !r_man && w_step) r_sh_mode <= w_auto_mode;
      if (frame_start) begin
        r_mode  <= (!r_man && w_step) ? w_auto_mode : r_sh_mode;
        r_color <= color_lut(r_sh_cidx);
        r_auto  <= r_sh_auto;
        r_fcnt  <= (!r_auto || r_sh_auto != r_auto || w_step) ? '0 : r_fcnt + FCNT_W'(1);
      end
    end
  end
endmodule
